// File: rtl/uart_tx_frame_arbiter.sv
// uart_tx_frame_arbiter: round-robin arbiter feeding whole frames from NUM_REQ producers into one UART TX FIFO.
// Build macro UART_TX_ARB_CRLF_EN appends 0x0D 0x0A to every frame.
module uart_tx_frame_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int LEN_W   = 5,
    parameter int MAX_LEN = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*LEN_W-1:0] i_len,
    input  logic [NUM_REQ*8-1:0]     i_byte,
    input  logic                     i_tx_full,
    output logic [NUM_REQ-1:0]       o_gnt,
    output logic [LEN_W-1:0]         o_idx,
    output logic                     o_tx_push,
    output logic [7:0]               o_tx_data,
    output logic                     o_busy,
    output logic                     o_frame_done,
    output logic                     o_overrun
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [3:0] {IDLE, GRANT, SEND, WAIT, DONE, CR, WCR, LF, WLF} state_t;

`ifdef UART_TX_ARB_CRLF_EN
    localparam state_t TAIL = CR;
`else
    localparam state_t TAIL = DONE;
`endif

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] pend_q, pend_d, gnt_q, gnt_d, rq_q, rq_d, clr;
    logic [PW-1:0]      ptr_q, ptr_d, win_q, win_d, pick;
    logic [LEN_W-1:0]   len_q, len_d, idx_q, idx_d, len_in;
    logic [7:0]         data_q, data_d, byte_in;
    logic               push_q, push_d, ovr_q;
    int                 j;

    // Winner is the first pending requester at or after ptr, wrapping around.
    always_comb begin
        pick = ptr_q;
        len_in = '0;
        byte_in = '0;
        j = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(ptr_q) + i;
            j = (j >= NUM_REQ) ? j - NUM_REQ : j;
            pick = pend_q[PW'(j)] ? PW'(j) : pick;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            len_in = (pick == PW'(k)) ? i_len[k*LEN_W +: LEN_W] : len_in;
            byte_in = (win_q == PW'(k)) ? i_byte[k*8 +: 8] : byte_in;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d = win_q;
        gnt_d = gnt_q;
        len_d = len_q;
        idx_d = idx_q;
        ptr_d = ptr_q;
        data_d = data_q;
        push_d = 1'b0;
        rq_d = rq_q | (i_req & gnt_q);
        clr = '0;
        case (state_q)
            IDLE: state_d = (|pend_q) ? GRANT : IDLE;
            GRANT: begin
                win_d = pick;
                gnt_d = NUM_REQ'(1) << pick;
                len_d = (len_in > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_in;
                idx_d = '0;
                state_d = (len_d == '0) ? TAIL : SEND;
            end
            SEND: if (!i_tx_full) begin
                push_d = 1'b1;
                data_d = byte_in;
                idx_d = idx_q + 1'b1;
                state_d = WAIT;
            end
            WAIT: state_d = (idx_q == len_q) ? TAIL : SEND;
`ifdef UART_TX_ARB_CRLF_EN
            CR: if (!i_tx_full) begin
                push_d = 1'b1;
                data_d = 8'h0D;
                state_d = WCR;
            end
            WCR: state_d = LF;
            LF: if (!i_tx_full) begin
                push_d = 1'b1;
                data_d = 8'h0A;
                state_d = WLF;
            end
            WLF: state_d = DONE;
`endif
            DONE: begin
                clr = gnt_q;
                gnt_d = '0;
                rq_d = '0;
                ptr_d = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A re-request by the owner during its own frame survives the DONE clear.
    assign pend_d = (pend_q & ~(clr & ~rq_q)) | i_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q <= '0;
            gnt_q <= '0;
            rq_q <= '0;
            ptr_q <= '0;
            win_q <= '0;
            len_q <= '0;
            idx_q <= '0;
            data_q <= '0;
            push_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q <= pend_d;
            gnt_q <= gnt_d;
            rq_q <= rq_d;
            ptr_q <= ptr_d;
            win_q <= win_d;
            len_q <= len_d;
            idx_q <= idx_d;
            data_q <= data_d;
            push_q <= push_d;
            ovr_q <= |(i_req & pend_q & ~gnt_q);
        end
    end

    assign o_gnt = gnt_q;
    assign o_idx = idx_q;
    assign o_tx_push = push_q;
    assign o_tx_data = data_q;
    assign o_busy = (state_q != IDLE);
    assign o_frame_done = (state_q == DONE);
    assign o_overrun = ovr_q;
endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// tb_uart_tx_frame_arbiter: directed stimulus checked every cycle against a queue-based frame model,
// plus literal expectations for ordering, timing, clamping, overrun and reset.
module tb_uart_tx_frame_arbiter;
    localparam int N  = 3;
    localparam int LW = 5;
`ifdef UART_TX_ARB_CRLF_EN
    localparam int CRLF = 2;
`else
    localparam int CRLF = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  i_req = '0;
    logic [N*LW-1:0] i_len;
    logic [N*8-1:0]  i_byte;
    logic          i_tx_full = 1'b0;
    logic [N-1:0]  o_gnt;
    logic [LW-1:0] o_idx;
    logic          o_tx_push, o_busy, o_frame_done, o_overrun;
    logic [7:0]    o_tx_data;

    logic [7:0] mem [N][32];
    int len_v [N];
    int cyc = 0, n_chk = 0, n_err = 0, done_cnt = 0, ovr_cnt = 0;
    int logd [$], logc [$], logo [$];

    uart_tx_frame_arbiter #(.NUM_REQ(N), .LEN_W(LW), .MAX_LEN(16)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_len(i_len), .i_byte(i_byte), .i_tx_full(i_tx_full),
        .o_gnt(o_gnt), .o_idx(o_idx), .o_tx_push(o_tx_push), .o_tx_data(o_tx_data),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            i_len[k*LW +: LW] = LW'(len_v[k]);
            i_byte[k*8 +: 8] = mem[k][o_idx];
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int oh(input logic [N-1:0] g);
        for (int k = 0; k < N; k++) if (g[k]) return k;
        return -1;
    endfunction

    // Frame-level model: pending set, rr pointer, and a byte queue built when a frame is granted.
    logic [N-1:0] m_pend = '0;
    int m_ptr = 0, m_ph = 0, m_nxt = 0, m_owner = 0, m_len = 0, m_idx = 0;
    bit m_gap = 0, m_rq = 0;
    logic [7:0] mq [$];
    logic e_push = 0, e_done = 0, e_ovr = 0, e_busy = 0;
    logic [7:0] e_data = '0;
    logic [N-1:0] e_gnt = '0;
    int e_idx = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = '0; m_ptr = 0; m_ph = 0; m_owner = 0; m_len = 0; m_idx = 0; m_gap = 0; m_rq = 0;
            mq.delete();
            e_push = 0; e_data = '0; e_done = 0; e_ovr = 0; e_busy = 0; e_gnt = '0; e_idx = 0;
        end else begin
            e_ovr = 0;
            for (int k = 0; k < N; k++)
                if (i_req[k] && m_pend[k] && !(m_ph >= 2 && m_owner == k)) e_ovr = 1;
            if (m_ph == 2 && i_req[m_owner]) m_rq = 1;
            e_push = 0;
            m_nxt = m_ph;
            if (m_ph == 0) begin
                if (m_pend != '0) m_nxt = 1;
            end else if (m_ph == 1) begin
                for (int i = N - 1; i >= 0; i--) if (m_pend[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
                m_len = (len_v[m_owner] > 16) ? 16 : len_v[m_owner];
                mq.delete();
                for (int i = 0; i < m_len; i++) mq.push_back(mem[m_owner][i]);
                if (CRLF != 0) begin mq.push_back(8'h0D); mq.push_back(8'h0A); end
                m_idx = 0;
                m_gap = 0;
                m_nxt = (mq.size() == 0) ? 3 : 2;
            end else if (m_ph == 2) begin
                if (m_gap) begin
                    m_gap = 0;
                    if (mq.size() == 0) m_nxt = 3;
                end else if (!i_tx_full) begin
                    e_push = 1;
                    e_data = mq.pop_front();
                    m_gap = 1;
                    if (m_idx < m_len) m_idx++;
                end
            end else begin
                m_pend[m_owner] = m_rq;
                m_rq = 0;
                m_ptr = (m_owner + 1) % N;
                m_nxt = 0;
            end
            m_pend = m_pend | i_req;
            m_ph = m_nxt;
            e_busy = (m_ph != 0);
            e_gnt = (m_ph >= 2) ? N'(1) << m_owner : '0;
            e_done = (m_ph == 3);
            e_idx = m_idx;
        end
    end

    always @(negedge clk) begin
        chk("busy", int'(o_busy), int'(e_busy));
        chk("gnt", int'(o_gnt), int'(e_gnt));
        chk("idx", int'(o_idx), e_idx);
        chk("push", int'(o_tx_push), int'(e_push));
        chk("frame_done", int'(o_frame_done), int'(e_done));
        chk("overrun", int'(o_overrun), int'(e_ovr));
        if (e_push) chk("data", int'(o_tx_data), int'(e_data));
        if (o_tx_push) begin
            logd.push_back(int'(o_tx_data));
            logc.push_back(cyc);
            logo.push_back(oh(o_gnt));
        end
        done_cnt += int'(o_frame_done);
        ovr_cnt += int'(o_overrun);
    end

    task automatic pulse(input logic [N-1:0] r, output int c);
        @(posedge clk); #2;
        i_req = r;
        c = cyc;
        @(posedge clk); #2;
        i_req = '0;
    endtask

    task automatic wait_quiet();
        int q = 0;
        for (int t = 0; t < 400 && q < 4; t++) begin
            @(negedge clk);
            q = o_busy ? 0 : q + 1;
        end
        chk("quiet_timeout", q, 4);
    endtask

    task automatic wait_push(input int n);
        int seen = 0;
        for (int t = 0; t < 400 && seen < n; t++) begin
            @(negedge clk);
            if (o_tx_push) seen++;
        end
        chk("push_timeout", seen, n);
    endtask

    task automatic chk_frame(input string nm, input int m, input int k, input int n);
        for (int i = 0; i < n + CRLF; i++) begin
            if (m + i < logd.size()) begin
                chk(nm, logd[m + i], (i < n) ? int'(mem[k][i]) : ((i == n) ? 'h0D : 'h0A));
                chk({nm, "_owner"}, logo[m + i], k);
            end
        end
    endtask

    initial begin
        int c, m, d0, o0, cf, w, per;
        int ex1 [5];
        int ord2 [2];
        ex1 = '{'h41, 'h42, 'h43, 'h0D, 'h0A};
        ord2 = '{0, 2};
        for (int k = 0; k < N; k++)
            for (int i = 0; i < 32; i++) mem[k][i] = 8'((k + 1) * 16 + i);
        mem[1][0] = 8'h41; mem[1][1] = 8'h42; mem[1][2] = 8'h43;
        len_v = '{0, 3, 0};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_gnt", int'(o_gnt), 0);
        chk("rst_push", int'(o_tx_push), 0);
        chk("rst_data", int'(o_tx_data), 0);
        @(posedge clk); #2;
        rst = 1'b0;

        // single request, "ABC"
        m = logd.size(); d0 = done_cnt;
        pulse(3'b010, c);
        wait_quiet();
        chk("t1_pushes", logd.size() - m, 3 + CRLF);
        for (int i = 0; i < 3 + CRLF; i++) begin
            if (m + i < logd.size()) begin
                chk("t1_byte", logd[m + i], ex1[i]);
                chk("t1_cycle", logc[m + i] - c, 4 + 2 * i);
            end
        end
        chk("t1_done", done_cnt - d0, 1);

        // simultaneous requests from reset
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        len_v = '{2, 2, 2};
        per = 2 + CRLF;
        m = logd.size();
        pulse(3'b111, c);
        wait_quiet();
        chk("t2_pushes", logd.size() - m, 3 * per);
        for (int i = 0; i < 3 * per; i++) if (m + i < logd.size()) chk("t2_order", logo[m + i], i / per);
        m = logd.size();
        pulse(3'b101, c);
        wait_quiet();
        chk("t2b_pushes", logd.size() - m, 2 * per);
        for (int i = 0; i < 2 * per; i++) if (m + i < logd.size()) chk("t2b_order", logo[m + i], ord2[i / per]);

        // backpressure for 10 cycles mid-frame
        len_v[0] = 5;
        m = logd.size();
        pulse(3'b001, c);
        wait_push(2);
        @(posedge clk); #2;
        i_tx_full = 1'b1;
        cf = cyc;
        repeat (10) @(posedge clk);
        #2 i_tx_full = 1'b0;
        wait_quiet();
        chk("t3_pushes", logd.size() - m, 5 + CRLF);
        chk_frame("t3_byte", m, 0, 5);
        w = 0;
        for (int i = m; i < logd.size(); i++) if (logc[i] >= cf && logc[i] <= cf + 10) w++;
        chk("t3_push_while_full", w, 0);

        // length edges: zero and clamped
        len_v[2] = 0;
        m = logd.size(); d0 = done_cnt;
        pulse(3'b100, c);
        wait_quiet();
        chk("t4_zero_pushes", logd.size() - m, CRLF);
        chk("t4_zero_done", done_cnt - d0, 1);
        len_v[2] = 20;
        m = logd.size();
        pulse(3'b100, c);
        wait_quiet();
        chk("t4_clamp_pushes", logd.size() - m, 16 + CRLF);
        chk_frame("t4_clamp_byte", m, 2, 16);

        // overrun on a pending, ungranted requester
        len_v[0] = 3; len_v[2] = 2;
        m = logd.size(); d0 = done_cnt; o0 = ovr_cnt;
        pulse(3'b001, c);
        pulse(3'b100, c);
        repeat (2) @(posedge clk);
        pulse(3'b100, c);
        wait_quiet();
        chk("t5_overrun", ovr_cnt - o0, 1);
        chk("t5_done", done_cnt - d0, 2);
        chk("t5_pushes", logd.size() - m, 5 + 2 * CRLF);
        chk_frame("t5_f0", m, 0, 3);
        chk_frame("t5_f2", m + 3 + CRLF, 2, 2);

        // owner re-request during its own frame re-queues
        len_v[0] = 2;
        m = logd.size(); d0 = done_cnt; o0 = ovr_cnt;
        pulse(3'b001, c);
        repeat (3) @(posedge clk);
        pulse(3'b001, c);
        wait_quiet();
        chk("t5b_overrun", ovr_cnt - o0, 0);
        chk("t5b_done", done_cnt - d0, 2);
        chk("t5b_pushes", logd.size() - m, 4 + 2 * CRLF);
        chk_frame("t5b_f1", m, 0, 2);
        chk_frame("t5b_f2", m + 2 + CRLF, 0, 2);

        // reset mid-frame
        len_v[1] = 5;
        pulse(3'b010, c);
        wait_push(2);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("t6_busy", int'(o_busy), 0);
        chk("t6_gnt", int'(o_gnt), 0);
        chk("t6_idx", int'(o_idx), 0);
        chk("t6_data", int'(o_tx_data), 0);
        @(posedge clk); #2 rst = 1'b0;
        m = logd.size();
        repeat (6) @(posedge clk);
        chk("t6_no_resume", logd.size() - m, 0);
        pulse(3'b010, c);
        wait_quiet();
        chk("t6_pushes", logd.size() - m, 5 + CRLF);
        chk_frame("t6_byte", m, 1, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
